hilo_sequencer: RTL

- Controller that sequences the multiplier and divider units and the Hi/Lo register writes of the multicycle CPU.
- The main control FSM issues a one-cycle start with an opcode. This block then:
  - pulses StartMult or StartDiv,
  - waits for MultEnd/DivEnd,
  - drives the Hi/Lo source select and write enables,
  - reports done, divide-by-zero or timeout.
- The main control stalls on busy.

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/hilo_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multicycle CPU control blocks.
//   hilo_state_t : Hi/Lo sequencer FSM states
//   OP_MULT/OP_DIV : operation codes accepted by the Hi/Lo sequencer
//   CAUSE_ZERO/CAUSE_TMO : reason an operation ended in the EXC state
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        EXC    = 3'd4
    } hilo_state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;

    localparam logic CAUSE_ZERO = 1'b0;
    localparam logic CAUSE_TMO  = 1'b1;

    // Only MULT and DIV are implemented; the upper opcode bit marks illegal codes.
    function automatic logic isLegalOp(input logic [1:0] opCode);
        return (opCode == OP_MULT) || (opCode == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_sequencer.sv
// ---------------------------------------------------------------------------
// hilo_sequencer
// Launches the multiplier or divider on request from main control, waits for
// the unit to answer, then writes Hi/Lo or reports an exception.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   one-cycle request from main control
//   op[1:0]       in   00 MULT, 01 DIV, 10/11 illegal
//   abort         in   synchronous flush back to IDLE, no Hi/Lo write
//   MultEnd       in   multiplier result-valid pulse
//   DivEnd        in   divider result-valid pulse
//   DivZero       in   divider divide-by-zero flag
//   StartMult     out  one-cycle multiplier launch
//   StartDiv      out  one-cycle divider launch
//   HiLoSel       out  Hi/Lo input mux select (0 multiplier, 1 divider)
//   WrHigh/WrLow  out  Hi / Lo register load
//   busy          out  operation in progress, main control stalls
//   done          out  pulse, result written
//   div_zero_exc  out  pulse, divide-by-zero exception
//   timeout_err   out  pulse, unit never answered
//   illegal_op    out  pulse, start with an illegal opcode (combinational)
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; illegal opcodes flagged here
// LAUNCH| one-cycle StartMult/StartDiv pulse, counter cleared
// WAIT  | watching the latched unit's end/zero signals, counting
// WRITE | one-cycle Hi/Lo load and done pulse
// EXC   | one-cycle divide-by-zero or timeout report, no writes
// ---------------------------------------------------------------------------
module hilo_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       abort,
    input  logic       MultEnd,
    input  logic       DivEnd,
    input  logic       DivZero,
    output logic       StartMult,
    output logic       StartDiv,
    output logic       HiLoSel,
    output logic       WrHigh,
    output logic       WrLow,
    output logic       busy,
    output logic       done,
    output logic       div_zero_exc,
    output logic       timeout_err,
    output logic       illegal_op
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    hilo_state_t      stateQ, stateD;
    logic [1:0]       opQ, opD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             causeQ, causeD;

    logic             isDiv;
    logic             unitEnd;
    logic             unitZero;

    // Only the latched unit is listened to; the idle unit's strobes are noise.
    assign isDiv    = (opQ == OP_DIV);
    assign unitEnd  = isDiv ? DivEnd : MultEnd;
    assign unitZero = isDiv & DivZero;

    always_comb begin
        stateD = stateQ;
        opD    = opQ;
        cntD   = cntQ;
        causeD = causeQ;

        unique case (stateQ)
            IDLE: begin
                if (start && isLegalOp(op) && !abort) begin
                    opD    = op;
                    stateD = LAUNCH;
                end
            end
            LAUNCH: begin
                cntD   = '0;
                stateD = WAIT;
            end
            WAIT: begin
                // Divide-by-zero outranks a simultaneous end pulse.
                if (unitZero) begin
                    causeD = CAUSE_ZERO;
                    stateD = EXC;
                end else if (unitEnd) begin
                    stateD = WRITE;
                end else if (cntQ == CNT_LAST) begin
                    causeD = CAUSE_TMO;
                    stateD = EXC;
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            WRITE:   stateD = IDLE;
            EXC:     stateD = IDLE;
            default: stateD = IDLE;
        endcase

        // Abort only steers the next state; outputs of the current cycle are
        // Moore decodes, so a WRITE already in progress still completes.
        if (abort) begin
            stateD = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            opQ    <= OP_MULT;
            cntQ   <= '0;
            causeQ <= CAUSE_ZERO;
        end else begin
            stateQ <= stateD;
            opQ    <= opD;
            cntQ   <= cntD;
            causeQ <= causeD;
        end
    end

    assign busy         = (stateQ != IDLE);
    assign HiLoSel      = busy & opQ[0];
    assign StartMult    = (stateQ == LAUNCH) & (opQ == OP_MULT);
    assign StartDiv     = (stateQ == LAUNCH) & (opQ == OP_DIV);
    assign WrHigh       = (stateQ == WRITE);
    assign WrLow        = (stateQ == WRITE);
    assign done         = (stateQ == WRITE);
    assign div_zero_exc = (stateQ == EXC) & (causeQ == CAUSE_ZERO);
    assign timeout_err  = (stateQ == EXC) & (causeQ == CAUSE_TMO);

    // Gated by reset so every output reads 0 while reset is held.
    assign illegal_op   = reset & (stateQ == IDLE) & start & ~isLegalOp(op);

endmodule
